fp_divide_seq: RTL and testbench

- Sequential IEEE-754 single-precision divider (op1 / op2), companion to the combinational FP multiplier in the FP datapath.
- Uses the same start / serv / done / busy / overflow handshake as the multiplier, so one controller can issue either operation.
- Mantissa quotient is produced by restoring division, one bit per cycle. Result is truncated, not rounded, matching the multiplier's truncation.

---
 rtl/fp_pkg.sv | 41 ++++
 rtl/fp_div_mant_core.sv | 62 ++++++
 rtl/fp_divide_seq.sv | 168 ++++++++++++++++
 tb/tb_fp_divide_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP32 datapath types and constants for the sequential divider and the multiplier.
// Holds the struct view of a float, the bias and special encodings, and the divider state type.
package fp_pkg;

    localparam int EXP_BIAS = 127;
    localparam int Q_BITS   = 25;

    localparam logic [7:0] EXP_INF = 8'hFF;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    localparam fp32_t FP_POS_INF = fp32_t'(32'h7F80_0000);
    localparam fp32_t FP_ZERO    = fp32_t'(32'h0000_0000);

    typedef enum logic [2:0] {
        DIV_IDLE   = 3'd0,
        DIV_SETUP  = 3'd1,
        DIV_DIVIDE = 3'd2,
        DIV_NORM   = 3'd3,
        DIV_DONE   = 3'd4
    } div_state_t;

    function automatic fp32_t fp_inf(input logic sign);
        fp32_t r;
        r      = FP_POS_INF;
        r.sign = sign;
        return r;
    endfunction

    function automatic fp32_t fp_zero(input logic sign);
        fp32_t r;
        r      = FP_ZERO;
        r.sign = sign;
        return r;
    endfunction

endpackage

// File: rtl/fp_div_mant_core.sv
// Restoring mantissa divider: one quotient bit per cycle after a load.
// Owns the remainder, quotient and iteration counter; the top decides when to load.
module fp_div_mant_core
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        load,
    input  logic [24:0] rem_init,
    input  logic [24:0] div_init,
    output logic [24:0] q_out,
    output logic        q_valid
);

    logic [24:0] rem_r;
    logic [24:0] div_r;
    logic [24:0] q_r;
    logic [4:0]  cnt_r;
    logic        run_r;
    logic        ge_s;
    logic [24:0] diff_s;

    // Trial subtraction for the current iteration.
    always_comb begin
        ge_s   = (rem_r >= div_r);
        diff_s = ge_s ? (rem_r - div_r) : rem_r;
    end

    // q_valid marks the cycle whose clock edge writes the final quotient bit.
    assign q_valid = run_r && (cnt_r == 5'(Q_BITS - 1));
    assign q_out   = q_r;

    // Iterator registers: load seeds the operands, then one step per cycle while running.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rem_r <= 25'd0;
            div_r <= 25'd0;
            q_r   <= 25'd0;
            cnt_r <= 5'd0;
            run_r <= 1'b0;
        end else if (load) begin
            rem_r <= rem_init;
            div_r <= div_init;
            q_r   <= 25'd0;
            cnt_r <= 5'd0;
            run_r <= 1'b1;
        end else if (run_r) begin
            // remainder stays below 2*div, so the shifted-out MSB is always zero
            rem_r <= diff_s << 1;
            q_r   <= {q_r[23:0], ge_s};
            cnt_r <= cnt_r + 5'd1;
            run_r <= (cnt_r != 5'(Q_BITS - 1));
        end else begin
            rem_r <= rem_r;
            div_r <= div_r;
            q_r   <= q_r;
            cnt_r <= cnt_r;
            run_r <= 1'b0;
        end
    end

endmodule

// File: rtl/fp_divide_seq.sv
// Sequential fp32 divider top: FSM, special-case detection, exponent path and normalisation.
// Mantissa quotient comes from fp_div_mant_core; results are truncated, never rounded.
module fp_divide_seq
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        div_start,
    input  logic        div_serv,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] div_result,
    output logic        div_done,
    output logic        div_overflow,
    output logic        div_by_zero,
    output logic        div_busy
);

    div_state_t         state_r;
    fp32_t              op1_r;
    fp32_t              op2_r;
    logic               sign_r;
    logic signed [9:0]  exp_r;

    logic               sign_s;
    logic signed [9:0]  exp_diff_s;
    logic               special_s;
    fp32_t              spec_res_s;
    logic               spec_ovf_s;
    logic               spec_bz_s;
    logic signed [9:0]  exp_norm_s;
    logic [22:0]        frac_norm_s;
    logic               load_s;
    logic [24:0]        q_s;
    logic               q_valid_s;

    // Sign, biased exponent difference and special-case classification of the captured operands.
    always_comb begin
        sign_s     = op1_r.sign ^ op2_r.sign;
        exp_diff_s = 10'({2'b00, op1_r.exp}) - 10'({2'b00, op2_r.exp}) + 10'(EXP_BIAS);
        special_s  = 1'b1;
        spec_res_s = fp_zero(sign_s);
        spec_ovf_s = 1'b0;
        spec_bz_s  = 1'b0;
        if ((op2_r.exp == 8'd0) && (op2_r.frac == 23'd0)) begin
            spec_res_s = fp_inf(sign_s);
            spec_ovf_s = 1'b1;
            spec_bz_s  = 1'b1;
        end else if ((op1_r.exp == EXP_INF) || (op2_r.exp == EXP_INF)) begin
            spec_res_s = fp_inf(sign_s);
            spec_ovf_s = 1'b1;
        end else if (op1_r.exp == 8'd0) begin
            spec_res_s = fp_zero(sign_s);
        end else if (op2_r.exp == 8'd0) begin
            // denormal divisor is flushed, so it divides like zero
            spec_res_s = fp_inf(sign_s);
            spec_ovf_s = 1'b1;
            spec_bz_s  = 1'b1;
        end else begin
            special_s  = 1'b0;
        end
    end

    // Normalisation: a quotient below 1.0 needs one left shift and one less exponent.
    always_comb begin
        if (q_s[24]) begin
            frac_norm_s = q_s[23:1];
            exp_norm_s  = exp_r;
        end else begin
            frac_norm_s = q_s[22:0];
            exp_norm_s  = exp_r - 10'sd1;
        end
    end

    assign load_s = (state_r == DIV_SETUP) && !special_s;

    fp_div_mant_core u_mant_core (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (load_s),
        .rem_init ({2'b01, op1_r.frac}),
        .div_init ({2'b01, op2_r.frac}),
        .q_out    (q_s),
        .q_valid  (q_valid_s)
    );

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r      <= DIV_IDLE;
            op1_r        <= FP_ZERO;
            op2_r        <= FP_ZERO;
            sign_r       <= 1'b0;
            exp_r        <= 10'sd0;
            div_result   <= 32'd0;
            div_done     <= 1'b0;
            div_overflow <= 1'b0;
            div_by_zero  <= 1'b0;
            div_busy     <= 1'b0;
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    div_done <= 1'b0;
                    if (div_start) begin
                        op1_r    <= op1;
                        op2_r    <= op2;
                        div_busy <= 1'b1;
                        state_r  <= DIV_SETUP;
                    end else begin
                        div_busy <= 1'b0;
                    end
                end
                DIV_SETUP: begin
                    sign_r <= sign_s;
                    exp_r  <= exp_diff_s;
                    if (special_s) begin
                        div_result   <= spec_res_s;
                        div_overflow <= spec_ovf_s;
                        div_by_zero  <= spec_bz_s;
                        div_done     <= 1'b1;
                        div_busy     <= 1'b0;
                        state_r      <= DIV_DONE;
                    end else begin
                        div_overflow <= 1'b0;
                        div_by_zero  <= 1'b0;
                        state_r      <= DIV_DIVIDE;
                    end
                end
                DIV_DIVIDE: begin
                    if (q_valid_s) begin
                        state_r <= DIV_NORM;
                    end else begin
                        state_r <= DIV_DIVIDE;
                    end
                end
                DIV_NORM: begin
                    if (exp_norm_s >= 10'sd255) begin
                        div_result   <= fp_inf(sign_r);
                        div_overflow <= 1'b1;
                    end else if (exp_norm_s <= 10'sd0) begin
                        div_result   <= fp_zero(sign_r);
                        div_overflow <= 1'b0;
                    end else begin
                        div_result   <= {sign_r, exp_norm_s[7:0], frac_norm_s};
                        div_overflow <= 1'b0;
                    end
                    div_done <= 1'b1;
                    div_busy <= 1'b0;
                    state_r  <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (div_serv) begin
                        div_done <= 1'b0;
                        state_r  <= DIV_IDLE;
                    end else begin
                        state_r  <= DIV_DONE;
                    end
                end
                default: begin
                    state_r  <= DIV_IDLE;
                    div_done <= 1'b0;
                    div_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divide_seq.sv
// Self-checking bench for fp_divide_seq: directed cases plus randomized operands
// compared against an arithmetic reference model of truncated fp32 division.
module tb_fp_divide_seq;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        div_start;
    logic        div_serv;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] div_result;
    logic        div_done;
    logic        div_overflow;
    logic        div_by_zero;
    logic        div_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fp_divide_seq dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .div_start    (div_start),
        .div_serv     (div_serv),
        .op1          (op1),
        .op2          (op2),
        .div_result   (div_result),
        .div_done     (div_done),
        .div_overflow (div_overflow),
        .div_by_zero  (div_by_zero),
        .div_busy     (div_busy)
    );

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        bz;
        int          lat;
    } ref_t;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference: exact integer quotient of the 24-bit significands scaled by 2^24, truncated.
    function automatic ref_t ref_div(input logic [31:0] a, input logic [31:0] b);
        ref_t            r;
        logic            s;
        int              e1, e2, e;
        longint unsigned num, den, q;
        logic [31:0]     frac;
        s     = a[31] ^ b[31];
        e1    = int'(a[30:23]);
        e2    = int'(b[30:23]);
        r.res = {s, 31'd0};
        r.ovf = 1'b0;
        r.bz  = 1'b0;
        r.lat = 2;
        if (b[30:0] == 31'd0) begin
            r.res = {s, 8'hFF, 23'd0}; r.ovf = 1'b1; r.bz = 1'b1;
        end else if (e1 == 255 || e2 == 255) begin
            r.res = {s, 8'hFF, 23'd0}; r.ovf = 1'b1;
        end else if (e1 == 0) begin
            r.res = {s, 31'd0};
        end else if (e2 == 0) begin
            r.res = {s, 8'hFF, 23'd0}; r.ovf = 1'b1; r.bz = 1'b1;
        end else begin
            r.lat = 28;
            num   = 64'd8388608 + 64'(a[22:0]);
            den   = 64'd8388608 + 64'(b[22:0]);
            q     = (num << 24) / den;
            e     = e1 - e2 + 127;
            if (q >= 64'd16777216) begin
                frac = 32'((q >> 1) & 64'h7F_FFFF);
            end else begin
                frac = 32'(q & 64'h7F_FFFF);
                e    = e - 1;
            end
            if (e >= 255) begin
                r.res = {s, 8'hFF, 23'd0}; r.ovf = 1'b1;
            end else if (e <= 0) begin
                r.res = {s, 31'd0};
            end else begin
                r.res = {s, 8'(e), frac[22:0]};
            end
        end
        return r;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag, input bit serve);
        ref_t r;
        int   k;
        bit   busy_ok;
        r = ref_div(a, b);
        @(negedge clk);
        op1 = a; op2 = b; div_start = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        op1 = $urandom;
        op2 = $urandom;
        k = 0;
        busy_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (div_done) begin
                k = i;
                break;
            end
            if (!div_busy) busy_ok = 1'b0;
        end
        check_val({tag, " latency"}, 32'(k), 32'(r.lat));
        check_val({tag, " result"}, div_result, r.res);
        check_val({tag, " overflow"}, 32'(div_overflow), 32'(r.ovf));
        check_val({tag, " by_zero"}, 32'(div_by_zero), 32'(r.bz));
        check_val({tag, " busy during op"}, 32'(busy_ok), 32'd1);
        check_val({tag, " busy at done"}, 32'(div_busy), 32'd0);
        if (serve) begin
            div_serv = 1'b1;
            @(negedge clk);
            div_serv = 1'b0;
            check_val({tag, " done released"}, 32'(div_done), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] a, b, held;
        bit          hold_ok;
        n_rst = 1'b0; div_start = 1'b0; div_serv = 1'b0; op1 = 32'd0; op2 = 32'd0;
        repeat (3) @(negedge clk);
        check_val("reset result", div_result, 32'd0);
        check_val("reset flags", {28'd0, div_done, div_overflow, div_by_zero, div_busy}, 32'd0);
        n_rst = 1'b1;

        run_op(32'h40C0_0000, 32'h4000_0000, "6/2", 1'b1);
        run_op(32'h3F80_0000, 32'h4040_0000, "1/3", 1'b1);
        run_op(32'hBF80_0000, 32'h3F00_0000, "-1/0.5", 1'b1);
        run_op(32'h3F80_0000, 32'h0000_0000, "1/0", 1'b1);
        run_op(32'h0000_0000, 32'h4000_0000, "0/2", 1'b1);
        run_op(32'h7F00_0000, 32'h3E80_0000, "overflow", 1'b1);
        run_op(32'h0080_0000, 32'h7F00_0000, "underflow", 1'b1);
        run_op(32'h7F80_0000, 32'h0000_0001, "inf/denorm", 1'b1);
        run_op(32'h4000_0000, 32'h0000_0001, "2/denorm", 1'b1);

        // Hold in DONE with a start pulse that must be ignored.
        run_op(32'h3F80_0000, 32'h4040_0000, "hold op", 1'b0);
        held = div_result;
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin op1 = 32'h40C0_0000; op2 = 32'h4000_0000; div_start = 1'b1; end
            if (i == 4) div_start = 1'b0;
            @(negedge clk);
            if (!div_done || div_busy || div_result !== held) hold_ok = 1'b0;
        end
        check_val("hold stable", 32'(hold_ok), 32'd1);
        check_val("hold value", held, 32'h3EAA_AAAA);
        div_serv = 1'b1; div_start = 1'b1;
        @(negedge clk);
        div_serv = 1'b0; div_start = 1'b0;
        check_val("serv+start done", 32'(div_done), 32'd0);
        check_val("serv+start busy", 32'(div_busy), 32'd0);
        @(negedge clk);
        check_val("start ignored busy", 32'(div_busy), 32'd0);
        check_val("start ignored done", 32'(div_done), 32'd0);

        // Reset during DIVIDE iteration 10.
        op1 = 32'h40C0_0000; op2 = 32'h4000_0000; div_start = 1'b1;
        @(posedge clk);
        #1 div_start = 1'b0;
        repeat (11) @(negedge clk);
        check_val("busy before reset", 32'(div_busy), 32'd1);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        check_val("midop reset result", div_result, 32'd0);
        check_val("midop reset flags", {28'd0, div_done, div_overflow, div_by_zero, div_busy}, 32'd0);
        run_op(32'h40C0_0000, 32'h4000_0000, "6/2 after reset", 1'b1);

        // Randomized operands, biased toward mid-range exponents with occasional specials.
        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: ;
                1, 2, 3: begin
                    a[30:23] = 8'($urandom_range(100, 154));
                    b[30:23] = 8'($urandom_range(100, 154));
                end
                4: begin
                    a[30:23] = 8'($urandom_range(1, 254));
                    b[30:23] = 8'($urandom_range(1, 254));
                end
                default: begin
                    if ($urandom_range(0, 1) == 0) a[30:23] = 8'hFF; else b[30:23] = 8'h00;
                end
            endcase
            run_op(a, b, $sformatf("rand%0d %h/%h", n, a, b), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
